seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised Mealy serial-pattern detector; next generation of the 1-bit "01" detector FSM.
//  Matches a runtime-loadable PAT_W-bit pattern with per-bit don't-care mask.
//  Supports overlapping/non-overlapping modes and a registered copy of the match pulse.
//  Sits between a serial bit source (qualified by valid) and event/interrupt logic.
// PARAMETERS
//  PAT_W    4        pattern length in bits (2..32)
//  PAT_INIT 4'b1011  pattern register reset value (PAT_W bits)
//  MSK_INIT 4'b1111  mask register reset value; 1 = bit compared, 0 = don't care
//  CNT_W    8        match counter width (used only with SEQ_DET_CNT_EN)
// PORTS
//  i_clk        in   1       clock, rising edge
//  i_rstn       in   1       asynchronous active-low reset
//  i_clr        in   1       synchronous clear of history/fill/counter (pattern kept)
//  i_load       in   1       load i_pat/i_mask into pattern/mask registers
//  i_pat        in   PAT_W   pattern; MSB = oldest bit of the sequence
//  i_mask       in   PAT_W   compare mask
//  i_overlap    in   1       1 = overlapping matches allowed, 0 = non-overlapping
//  i_valid      in   1       i_seq qualifier; bit consumed only when high
//  i_seq        in   1       serial data bit
//  o_match      out  1       Mealy match, combinational, same cycle as the last bit
//  o_match_r    out  1       o_match registered (1-cycle latency)
//  o_armed      out  1       1 when PAT_W-1 valid bits are held (next bit can match)
//  o_match_cnt  out  CNT_W   saturating match count (SEQ_DET_CNT_EN only)
// BEHAVIOUR
//  - Reset (async, i_rstn=0): hist=0, fill=0, pat_q=PAT_INIT, msk_q=MSK_INIT,
//    o_match_r=0, o_match_cnt=0. o_match=0 and o_armed=0 follow from fill=0.
//  - hist: (PAT_W-1)-bit shift register of past valid bits. fill: 0..PAT_W-1, saturating.
//  - FSM states (encoded by fill): FILL (fill<PAT_W-1) and ARMED (fill==PAT_W-1); o_armed = ARMED.
//  - Window w = {hist, i_seq}.
//    o_match = i_valid & ARMED & ~i_clr & ~i_load & ((w ^ pat_q) & msk_q) == 0.
//  - On a consumed bit (i_valid & ~i_clr & ~i_load): hist <= {hist[PAT_W-3:0], i_seq};
//    fill <= min(fill+1, PAT_W-1).
//  - Exception: o_match & ~i_overlap -> fill <= 0, state back to FILL. The next match needs
//    PAT_W fresh bits. hist still shifts.
//  - o_match & i_overlap: fill stays PAT_W-1; back-to-back matches on consecutive valid bits are legal.
//  - i_valid=0: no state change, o_match=0.
//  - Priority, per cycle: i_clr > i_load > data.
//    i_clr: hist=0, fill=0, counter=0; bit discarded.
//    i_load: pat_q/msk_q updated, hist=0, fill=0; bit discarded.
//  - o_match_r <= o_match every cycle, including while clear or load is active (it registers 0 then).
//  - msk_q=0: every bit in ARMED matches. Only meaningful for fill behaviour; this is legal.
//  - Async reset mid-sequence discards partial history; there is no pending-match carry-over.
// CONFIGURATION
//  SEQ_DET_CNT_EN defined:
//    o_match_cnt increments on each o_match.
//    Saturates at 2^CNT_W-1 (no wrap). Cleared by reset and i_clr; not cleared by i_load.
//  SEQ_DET_CNT_EN undefined:
//    o_match_cnt port removed; no counter logic.
// TESTING
//  1 Reset values: i_rstn=0 mid-stream -> all outputs 0 immediately; after release,
//    pat_q=1011 and 4 bits are needed before any match.
//  2 Overlap: i_overlap=1, bits 1,0,1,1,0,1,1 ->
//    o_match high on bits 4 and 7; o_match_r high 1 cycle later; cnt=2.
//  3 Non-overlap: i_overlap=0, same stream -> match on bit 4 only.
//    Stream 1,0,1,1,1,0,1,1 -> matches on bits 4 and 8.
//  4 Valid gaps and load: stream 1011 with i_valid=0 cycles inserted -> single match on the 4th valid bit.
//    i_load with pat=0110, mask=1001 in the same cycle as a bit -> bit dropped;
//    then 0,1,0,0 -> match (middle bits don't-care).
//  5 Priority: i_clr and i_load high together while ARMED -> fill=0, cnt=0, pattern updated, o_match=0.
//  6 Saturation (CNT_W=2, SEQ_DET_CNT_EN, overlap, pattern 11 mask 11):
//    six consecutive 1s -> 5 matches, cnt stops at 3.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Purpose:
//   Mealy serial-pattern detector with a runtime-loadable PAT_W-bit pattern
//   and a per-bit don't-care mask. Serial bits arrive on i_seq, qualified by
//   i_valid. The detector reports a match in the same cycle as the last bit of
//   the pattern. A registered copy of that pulse is also provided. Matches can
//   overlap or be kept non-overlapping.
//
// Optional feature:
//   SEQ_DET_CNT_EN - when defined, adds a saturating match counter and the
//                    o_match_cnt port. When undefined, the port and the
//                    counter logic are both absent.
//
// Parameters:
//   PAT_W    pattern length in bits (2..32)
//   PAT_INIT pattern register reset value
//   MSK_INIT mask register reset value (1 = bit compared, 0 = don't care)
//   CNT_W    match counter width (only used with SEQ_DET_CNT_EN)
//
// Ports:
//   i_clk        rising-edge clock
//   i_rstn       asynchronous active-low reset
//   i_clr        synchronous clear of history/fill/counter (pattern kept)
//   i_load       load i_pat/i_mask into the pattern/mask registers
//   i_pat        pattern; MSB is the oldest bit of the sequence
//   i_mask       compare mask
//   i_overlap    1 = overlapping matches, 0 = non-overlapping
//   i_valid      qualifier for i_seq
//   i_seq        serial data bit
//   o_match      combinational match, same cycle as the final bit
//   o_match_r    o_match delayed by one clock
//   o_armed      high when PAT_W-1 valid bits are held
//   o_match_cnt  saturating match count (SEQ_DET_CNT_EN only)
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
  parameter logic [PAT_W-1:0] MSK_INIT = 4'b1111,
  parameter int               CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [PAT_W-1:0] i_mask,
  input  logic             i_overlap,
  input  logic             i_valid,
  input  logic             i_seq,
  output logic             o_match,
  output logic             o_match_r,
  output logic             o_armed
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] o_match_cnt
`endif
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(PAT_W - 2);

  typedef enum logic {
    S_FILL,
    S_ARMED
  } state_t;

  state_t             state;
  logic [FILL_W-1:0]  fill;
  logic [PAT_W-2:0]   hist;
  logic [PAT_W-1:0]   pat_q;
  logic [PAT_W-1:0]   msk_q;
  logic [PAT_W-1:0]   window;
  logic               consume;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0]   match_cnt;
  assign o_match_cnt = match_cnt;
`else
  // CNT_W only sizes the counter; this keeps the parameter referenced when
  // the counter is compiled out.
  logic [CNT_W-1:0]   unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

  // The window to compare is the stored history followed by the bit arriving
  // this cycle, so that the match can be flagged in the same cycle as the
  // final bit. A bit is only consumed when neither clear nor load claims the
  // cycle. Masked-off positions never block a match.
  assign window  = {hist, i_seq};
  assign consume = i_valid & ~i_clr & ~i_load;
  assign o_armed = (state == S_ARMED);
  assign o_match = consume & (state == S_ARMED) &
                   (((window ^ pat_q) & msk_q) == '0);

  // Detector state. Clear and load both restart collection from scratch.
  // Load also replaces the pattern, even when clear is asserted in the same
  // cycle. Only clear resets the counter. On a consumed bit the history
  // always shifts. The fill count climbs toward PAT_W-1 and then holds there,
  // which lets overlapping matches fire back-to-back. A non-overlapping match
  // sends fill back to zero, so the next match needs a full set of fresh bits.
  // The registered match copy samples every cycle. It therefore captures 0
  // during clear/load cycles.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_FILL;
      fill      <= '0;
      hist      <= '0;
      pat_q     <= PAT_INIT;
      msk_q     <= MSK_INIT;
      o_match_r <= 1'b0;
`ifdef SEQ_DET_CNT_EN
      match_cnt <= '0;
`endif
    end else begin
      o_match_r <= o_match;

      if (i_load) begin
        pat_q <= i_pat;
        msk_q <= i_mask;
      end

      if (i_clr || i_load) begin
        hist  <= '0;
        fill  <= '0;
        state <= S_FILL;
      end else if (i_valid) begin
        hist <= window[PAT_W-2:0];
        if (o_match && !i_overlap) begin
          fill  <= '0;
          state <= S_FILL;
        end else if (fill != FILL_MAX) begin
          fill  <= fill + 1'b1;
          state <= (fill == FILL_PRE) ? S_ARMED : S_FILL;
        end
      end

`ifdef SEQ_DET_CNT_EN
      if (i_clr) begin
        match_cnt <= '0;
      end else if (o_match && (match_cnt != '1)) begin
        match_cnt <= match_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Purpose:
//   Self-checking bench for seq_detector_param (PAT_W=4, CNT_W=2). A reference
//   model keeps the list of consumed bits and a count of fresh bits. It uses
//   them to work out match, armed and count behaviour. Directed scenarios are
//   followed by a randomized stream. The counter is checked only when
//   SEQ_DET_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic             i_clr = 1'b0;
  logic             i_load = 1'b0;
  logic [PAT_W-1:0] i_pat = '0;
  logic [PAT_W-1:0] i_mask = '0;
  logic             i_overlap = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_seq = 1'b0;
  logic             o_match;
  logic             o_match_r;
  logic             o_armed;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] o_match_cnt;
`endif

  int total = 0;
  int bad   = 0;

  bit               m_bits[$];
  int               m_fresh;
  logic [PAT_W-1:0] m_pat;
  logic [PAT_W-1:0] m_msk;
  bit               m_prev;
  int               m_cnt;

  seq_detector_param #(
    .PAT_W   (PAT_W),
    .PAT_INIT(4'b1011),
    .MSK_INIT(4'b1111),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clr      (i_clr),
    .i_load     (i_load),
    .i_pat      (i_pat),
    .i_mask     (i_mask),
    .i_overlap  (i_overlap),
    .i_valid    (i_valid),
    .i_seq      (i_seq),
    .o_match    (o_match),
    .o_match_r  (o_match_r),
    .o_armed    (o_armed)
`ifdef SEQ_DET_CNT_EN
    ,
    .o_match_cnt(o_match_cnt)
`endif
  );

  // Free-running clock with a 10-unit period.
  always #5 i_clk = ~i_clk;

  // Puts the model back into its power-on condition.
  task automatic modelReset();
    m_bits.delete();
    m_fresh = 0;
    m_pat   = 4'b1011;
    m_msk   = 4'b1111;
    m_prev  = 1'b0;
    m_cnt   = 0;
  endtask

  // A match needs a valid, unclaimed bit and at least PAT_W-1 fresh bits
  // already held. Every compared position must also agree with the pattern.
  // Position 0 is the bit arriving now. Position k is the bit consumed k
  // steps earlier.
  function automatic bit modelMatch(input bit v, input bit s, input bit c,
                                    input bit l);
    bit b;
    if (!v || c || l || m_fresh < PAT_W - 1) return 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      b = (i == 0) ? s : m_bits[m_bits.size() - i];
      if (m_msk[i] && (b != m_pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advances the model by one clock using the stimulus that was just applied.
  task automatic modelUpdate(input bit v, input bit s, input bit c, input bit l,
                             input bit ov, input logic [PAT_W-1:0] p,
                             input logic [PAT_W-1:0] mk, input bit match);
    if (l) begin
      m_pat = p;
      m_msk = mk;
    end
    if (c) m_cnt = 0;
    if (c || l) begin
      m_fresh = 0;
    end else if (v) begin
      m_bits.push_back(s);
      if (m_bits.size() > 16) void'(m_bits.pop_front());
      if (match && !ov) m_fresh = 0;
      else if (m_fresh < PAT_W - 1) m_fresh++;
    end
    if (match && m_cnt < CNT_MAX) m_cnt++;
    m_prev = match;
  endtask

  // Compares every DUT output against the model's expectation.
  task automatic checkOutput(input string tag, input bit exp_match);
    total++;
    assert (o_match === exp_match) else begin
      bad++;
      $error("[TB] FAIL %s o_match observed=%0b expected=%0b", tag, o_match, exp_match);
    end
    total++;
    assert (o_armed === (m_fresh >= PAT_W - 1)) else begin
      bad++;
      $error("[TB] FAIL %s o_armed observed=%0b expected=%0b", tag, o_armed, (m_fresh >= PAT_W - 1));
    end
    total++;
    assert (o_match_r === m_prev) else begin
      bad++;
      $error("[TB] FAIL %s o_match_r observed=%0b expected=%0b", tag, o_match_r, m_prev);
    end
`ifdef SEQ_DET_CNT_EN
    total++;
    assert (o_match_cnt === CNT_W'(m_cnt)) else begin
      bad++;
      $error("[TB] FAIL %s o_match_cnt observed=%0d expected=%0d", tag, o_match_cnt, m_cnt);
    end
`endif
  endtask

  // Drives one cycle of inputs on the falling edge and checks the outputs
  // shortly afterwards. The model then advances on the rising edge.
  task automatic applyStimulus(input string tag, input bit v, input bit s,
                               input bit c, input bit l, input bit ov,
                               input logic [PAT_W-1:0] p,
                               input logic [PAT_W-1:0] mk);
    bit exp_match;
    @(negedge i_clk);
    i_valid   = v;
    i_seq     = s;
    i_clr     = c;
    i_load    = l;
    i_overlap = ov;
    i_pat     = p;
    i_mask    = mk;
    #1;
    exp_match = modelMatch(v, s, c, l);
    checkOutput(tag, exp_match);
    @(posedge i_clk);
    modelUpdate(v, s, c, l, ov, p, mk, exp_match);
  endtask

  // Feeds n bits MSB-first as consecutive valid cycles.
  task automatic feedStream(input string tag, input bit ov, input int n,
                            input logic [15:0] stream);
    for (int i = n - 1; i >= 0; i--)
      applyStimulus(tag, 1'b1, stream[i], 1'b0, 1'b0, ov, '0, '0);
  endtask

  // Asserts the asynchronous reset between clock edges and checks that the
  // outputs drop at once. The reset is released on a falling edge.
  task automatic doReset(input string tag);
    @(negedge i_clk);
    #3;
    i_rstn = 1'b0;
    #1;
    modelReset();
    checkOutput(tag, 1'b0);
    i_valid = 1'b0;
    i_clr   = 1'b0;
    i_load  = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  // Directed scenarios first, then a randomized stream with occasional
  // clear/load and random patterns, masks and overlap mode.
  initial begin
    logic [PAT_W-1:0] rp;
    logic [PAT_W-1:0] rm;
    int               sel;
    bit               rv, rs, rc, rl, ro;

    modelReset();
    doReset("por");

    $display("[TB] reset values and mid-stream reset");
    feedStream("pre_rst", 1'b1, 4, 16'b1011);
    doReset("mid_rst");
    feedStream("post_rst", 1'b1, 4, 16'b1011);

    $display("[TB] overlapping matches");
    applyStimulus("clr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
    feedStream("ovl", 1'b1, 7, 16'b1011011);
    applyStimulus("ovl_tail", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

    $display("[TB] non-overlapping matches");
    applyStimulus("clr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    feedStream("novl_a", 1'b0, 7, 16'b1011011);
    applyStimulus("clr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    feedStream("novl_b", 1'b0, 8, 16'b10111011);

    $display("[TB] valid gaps and pattern load");
    applyStimulus("clr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
    applyStimulus("gap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus("gap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus("gap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus("gap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus("gap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus("load", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 4'b1001);
    feedStream("dontcare", 1'b1, 4, 16'b0100);

    $display("[TB] clear and load together while armed");
    feedStream("arm", 1'b1, 3, 16'b101);
    applyStimulus("clr_load", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1100, 4'b1111);
    feedStream("new_pat", 1'b1, 4, 16'b1100);

    $display("[TB] counter saturation and empty mask");
    applyStimulus("load_ones", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111);
    applyStimulus("clr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
    feedStream("sat", 1'b1, 8, 16'hFF);
    applyStimulus("load_nomask", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    feedStream("nomask", 1'b0, 9, 16'b101100101);

    $display("[TB] randomized stream");
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 99));
      rv  = ($urandom_range(0, 9) < 7);
      rs  = 1'($urandom);
      rc  = (sel < 3);
      rl  = (sel >= 3 && sel < 7) || (sel == 50);
      ro  = ($urandom_range(0, 3) != 0);
      rp  = PAT_W'($urandom);
      rm  = ($urandom_range(0, 3) == 0) ? PAT_W'($urandom) : '1;
      applyStimulus("rand", rv, rs, rc, rl, ro, rp, rm);
      if (n == 300) doReset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
